// File: rtl/arb_req_ctrl_pkg.sv
// arb_req_ctrl_pkg: slot state encoding, shared size defaults and clog2 for the requester/arbiter pair
package arb_req_ctrl_pkg;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        XFER    = 2'd2,
        RELEASE = 2'd3
    } slot_state_e;

    localparam int DEF_DW     = 4;
    localparam int DEF_LW     = 4;
    localparam int DEF_DATA_W = 32;

    function automatic int clog2(input int n);
        int r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) r++;
        return r;
    endfunction
endpackage

// File: rtl/arb_req_slot.sv
// arb_req_slot: per-client command FSM holding the captured burst length and the completion pulse
module arb_req_slot
    import arb_req_ctrl_pkg::*;
#(
    parameter int LW = DEF_LW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    input  logic [LW-1:0] cmd_len,
    input  logic          take,
    input  logic          fin,
    output slot_state_e   state,
    output logic [LW-1:0] len_reg,
    output logic          done
);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            len_reg <= '0;
            done    <= 1'b0;
        end else begin
            done <= state == XFER && fin;
            case (state)
                IDLE:    if (cmd_valid) begin
                             state   <= REQ;
                             len_reg <= cmd_len;
                         end
                REQ:     if (take) state <= XFER;
                XFER:    if (fin) state <= RELEASE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: rtl/arb_req_ctrl.sv
// arb_req_ctrl: raises per-client arbiter requests and sequences the granted client's burst onto the shared bus
module arb_req_ctrl
    import arb_req_ctrl_pkg::*;
#(
    parameter int DW     = DEF_DW,
    parameter int LW     = DEF_LW,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DW-1:0]          cmd_valid,
    output logic [DW-1:0]          cmd_ready,
    input  logic [DW*LW-1:0]       cmd_len,
    input  logic [DW*DATA_W-1:0]   cmd_data,
    output logic [DW-1:0]          done,
    output logic [DW-1:0]          req,
    input  logic [DW-1:0]          grant,
    output logic                   bus_valid,
    input  logic                   bus_ready,
    output logic [clog2(DW)-1:0]   bus_sel,
    output logic [DATA_W-1:0]      bus_data,
    output logic                   bus_last
);
    localparam int SW = clog2(DW);

    slot_state_e           st [DW];
    logic [DW-1:0][LW-1:0] len_reg;
    logic [DW-1:0]         in_req, in_xfer, elig, take, fin;
    logic [LW-1:0]         beat_cnt;
    logic [SW-1:0]         sel;
    logic                  any_xfer, fire;

    for (genvar i = 0; i < DW; i++) begin : g_slot
        arb_req_slot #(.LW(LW)) u_slot (
            .clk       (clk),
            .rst       (rst),
            .cmd_valid (cmd_valid[i]),
            .cmd_len   (cmd_len[i*LW +: LW]),
            .take      (take[i]),
            .fin       (fin[i]),
            .state     (st[i]),
            .len_reg   (len_reg[i]),
            .done      (done[i])
        );
        assign in_req[i]    = st[i] == REQ;
        assign in_xfer[i]   = st[i] == XFER;
        assign cmd_ready[i] = st[i] == IDLE;
    end

    always_comb begin
        sel = '0;
        for (int i = DW - 1; i >= 0; i--) sel = in_xfer[i] ? SW'(i) : sel;
    end

    // Grants only count for slots waiting in REQ; lowest index wins and nothing is taken mid-burst.
    assign any_xfer = |in_xfer;
    assign elig     = grant & in_req;
    assign take     = any_xfer ? '0 : elig & (~elig + DW'(1));
    assign req      = any_xfer ? in_xfer : in_req;

    assign fire      = any_xfer & bus_ready;
    assign bus_valid = any_xfer;
    assign bus_sel   = sel;
    assign bus_last  = any_xfer && beat_cnt == len_reg[sel];
    assign bus_data  = any_xfer ? cmd_data[int'(sel)*DATA_W +: DATA_W] : '0;
    assign fin       = in_xfer & {DW{fire & bus_last}};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) beat_cnt <= '0;
        else      beat_cnt <= |take ? '0 : fire ? beat_cnt + LW'(1) : beat_cnt;
    end
endmodule
